// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler.
// Optional statistics counters are enabled with the AES_SCHED_STATS_EN macro.
package aes_sched_pkg;

    localparam int NR_DEFAULT     = 10;
    localparam int DATA_W_DEFAULT = 128;
    localparam int RIDX_W_DEFAULT = 4;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    // Saturating 16-bit increment for event counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/aes_core_scheduler_if.sv
// Request/response bus between the two clients and the AES core scheduler.
// The scheduler is the slave; the clients side (bench or glue) is the master.
interface aes_core_scheduler_if #(
    parameter int DATA_W = 128
);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_mode;
    logic [2*DATA_W-1:0] req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_id;
    logic                rsp_mode;

    modport slave (
        input  req_valid, req_mode, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_mode
    );

    modport master (
        output req_valid, req_mode, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_mode
    );
endinterface

// File: rtl/aes_core_scheduler_rr_arb2.sv
// Two-way round-robin arbiter: a lone valid wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_enable,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);
    logic w_pick;

    assign w_pick     = (&i_valid) ? ~i_last_grant : i_valid[1];
    assign o_grant_id = w_pick;

    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign o_grant[gi] = i_enable & i_valid[gi] & (w_pick == 1'(gi));
    end
endmodule

// File: rtl/aes_core_scheduler.sv
// Sequences a shared iterative AES round core for two requesters: grant,
// load, NR rounds, capture, then hold the response. Stats via AES_SCHED_STATS_EN.
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NR     = NR_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int RIDX_W = RIDX_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_core_scheduler_if.slave   bus,
    output logic                  o_core_load,
    output logic                  o_core_en,
    output logic                  o_core_last,
    output logic                  o_core_mode,
    output logic [DATA_W-1:0]     o_core_din,
    output logic [RIDX_W-1:0]     o_key_sel,
    input  logic [DATA_W-1:0]     i_core_dout,
    output logic                  o_busy,
    output logic [15:0]           o_stat_enc_cnt,
    output logic [15:0]           o_stat_dec_cnt
);
    if ((1 << RIDX_W) <= NR) begin : g_ridx_check
        $error("aes_core_scheduler: RIDX_W too narrow to index round key NR");
    end

    localparam logic [RIDX_W-1:0] NR_IDX = RIDX_W'(NR);

    state_t              r_state;
    state_t              w_state_next;
    logic [RIDX_W-1:0]   r_round_idx;
    logic                r_last_grant;
    logic                r_id;
    logic                r_mode;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [1:0]          w_grant;
    logic                w_grant_id;
    logic                w_final_round;

    rr_arb2 u_arb (
        .i_valid      (bus.req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (r_state == ST_IDLE),
        .o_grant      (w_grant),
        .o_grant_id   (w_grant_id)
    );

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_mode   = r_mode;
    assign o_core_mode    = r_mode;
    assign o_core_din     = r_din;
    assign o_busy         = (r_state != ST_IDLE);
    assign w_final_round  = (r_round_idx == NR_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_core_load  = 1'b0;
        o_core_en    = 1'b0;
        o_core_last  = 1'b0;
        o_key_sel    = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                o_core_load  = 1'b1;
                o_key_sel    = (r_mode == MODE_DEC) ? NR_IDX : '0;
                w_state_next = ST_ROUND;
            end
            ST_ROUND: begin
                // Decrypt walks the expanded key from the top down
                o_core_en   = 1'b1;
                o_core_last = w_final_round;
                o_key_sel   = (r_mode == MODE_DEC) ? (NR_IDX - r_round_idx) : r_round_idx;
                if (w_final_round) w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round_idx  <= '0;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_mode       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_din        <= '0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_id         <= w_grant_id;
                        r_mode       <= bus.req_mode[w_grant_id];
                        r_din        <= w_grant_id ? bus.req_data[2*DATA_W-1:DATA_W]
                                                   : bus.req_data[DATA_W-1:0];
                        r_last_grant <= w_grant_id;
                    end
                end
                ST_LOAD: begin
                    r_round_idx <= RIDX_W'(1);
                end
                ST_ROUND: begin
                    r_round_idx <= r_round_idx + RIDX_W'(1);
                end
                ST_CAPTURE: begin
                    r_rsp_data  <= i_core_dout;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AES_SCHED_STATS_EN
    logic w_rsp_hs;
    assign w_rsp_hs = r_rsp_valid & bus.rsp_ready;

    // Counter gi counts completed responses whose mode encoding equals gi
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_rsp_hs && (r_mode == 1'(gi))) begin
                r_cnt <= sat_inc16(r_cnt);
            end
        end
    end

    assign o_stat_enc_cnt = g_stat[0].r_cnt;
    assign o_stat_dec_cnt = g_stat[1].r_cnt;
`else
    assign o_stat_enc_cnt = '0;
    assign o_stat_dec_cnt = '0;
`endif

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Bench for aes_core_scheduler: a stand-in round core plus a behavioural
// model of the op timeline, arbitration, responses and AES_SCHED_STATS_EN counters.
module tb_aes_core_scheduler;
    localparam int NR = 10;
    localparam int DW = 128;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_core_scheduler_if #(.DATA_W(DW)) bus();

    logic          core_load, core_en, core_last, core_mode, busy;
    logic [DW-1:0] core_din;
    logic [DW-1:0] core_dout = '0;
    logic [RW-1:0] key_sel;
    logic [15:0]   st_enc, st_dec;

    aes_core_scheduler #(.NR(NR), .DATA_W(DW), .RIDX_W(RW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .o_core_load    (core_load),
        .o_core_en      (core_en),
        .o_core_last    (core_last),
        .o_core_mode    (core_mode),
        .o_core_din     (core_din),
        .o_key_sel      (key_sel),
        .i_core_dout    (core_dout),
        .o_busy         (busy),
        .o_stat_enc_cnt (st_enc),
        .o_stat_dec_cnt (st_dec)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Stand-in round core: key k is a repeated byte, a round is rotate + key
    function automatic logic [DW-1:0] key_of(input int k);
        return {16{8'(k * 37 + 11)}};
    endfunction

    function automatic logic [DW-1:0] round_fn(input logic [DW-1:0] s, input int k,
                                               input bit last, input bit mode);
        logic [DW-1:0] r;
        r = {s[DW-9:0], s[DW-1:DW-8]} ^ key_of(k);
        if (last) r = r ^ {{(DW-1){1'b0}}, 1'b1};
        if (mode) r = r ^ {16{8'hA5}};
        return r;
    endfunction

    function automatic logic [DW-1:0] expect_result(input logic [DW-1:0] d, input bit mode);
        logic [DW-1:0] s;
        s = d ^ key_of(mode ? NR : 0);
        for (int r = 1; r <= NR; r++) s = round_fn(s, mode ? NR - r : r, r == NR, mode);
        return s;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        if (core_load)    core_dout <= core_din ^ key_of(int'(key_sel));
        else if (core_en) core_dout <= round_fn(core_dout, int'(key_sel), core_last, core_mode);
    end

    // Behavioural model: op position counted in cycles from the request handshake
    bit            m_busy = 1'b0;
    int            m_off = 0;
    bit            m_id = 1'b0, m_mode = 1'b0, m_last_grant = 1'b1;
    logic [DW-1:0] m_data = '0, m_exp = '0;
    int            m_enc = 0, m_dec = 0;

    always @(negedge clk) begin : monitor
        logic [1:0] exp_gnt;
        bit         e_load, e_en, e_last;
        int         e_key;
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_core_en", core_en, 0);
            chk("rst_core_load", core_load, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_core_din", core_din, 0);
            chk("rst_stat_enc", st_enc, 0);
            chk("rst_stat_dec", st_dec, 0);
            m_busy = 1'b0; m_last_grant = 1'b1; m_data = '0; m_mode = 1'b0;
            m_id = 1'b0; m_enc = 0; m_dec = 0;
        end else begin
`ifdef AES_SCHED_STATS_EN
            chk("stat_enc", st_enc, 16'(m_enc));
            chk("stat_dec", st_dec, 16'(m_dec));
`else
            chk("stat_enc_off", st_enc, 0);
            chk("stat_dec_off", st_dec, 0);
`endif
            chk("core_mode", core_mode, m_mode);
            chk("core_din", core_din, m_data);
            if (!m_busy) begin
                exp_gnt = (bus.req_valid == 2'b11) ? (m_last_grant ? 2'b01 : 2'b10) : bus.req_valid;
                chk("req_ready", bus.req_ready, exp_gnt);
                chk("idle_busy", busy, 0);
                chk("idle_core_ctl", {core_load, core_en, core_last}, 0);
                chk("idle_key_sel", key_sel, 0);
                chk("idle_rsp_valid", bus.rsp_valid, 0);
                if (|exp_gnt) begin
                    m_id   = exp_gnt[1];
                    m_mode = bus.req_mode[m_id];
                    m_data = m_id ? bus.req_data[2*DW-1:DW] : bus.req_data[DW-1:0];
                    m_exp  = expect_result(m_data, m_mode);
                    m_last_grant = m_id;
                    m_busy = 1'b1;
                    m_off  = 0;
                end
            end else begin
                m_off++;
                e_load = (m_off == 1);
                e_en   = (m_off >= 2) && (m_off <= NR + 1);
                e_last = (m_off == NR + 1);
                e_key  = e_load ? (m_mode ? NR : 0) :
                         e_en   ? (m_mode ? NR - (m_off - 1) : m_off - 1) : 0;
                chk("op_busy", busy, 1);
                chk("op_req_ready", bus.req_ready, 0);
                chk("core_load", core_load, e_load);
                chk("core_en", core_en, e_en);
                chk("core_last", core_last, e_last);
                chk("key_sel", key_sel, e_key);
                chk("rsp_valid", bus.rsp_valid, m_off >= NR + 3);
                if (m_off >= NR + 3) begin
                    chk("rsp_data", bus.rsp_data, m_exp);
                    chk("rsp_id", bus.rsp_id, m_id);
                    chk("rsp_mode", bus.rsp_mode, m_mode);
                    if (bus.rsp_ready) begin
                        if (m_mode) begin if (m_dec < 65535) m_dec++; end
                        else        begin if (m_enc < 65535) m_enc++; end
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_accept(input int i);
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.req_valid[i] && bus.req_ready[i]) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (!ok) timeout("accept");
    endtask

    task automatic wait_any_accept(output int id);
        bit ok = 1'b0;
        id = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) begin
                id = bus.req_ready[1] ? 1 : 0; ok = 1'b1; break;
            end
        end
        @(posedge clk); #1;
        if (!ok) timeout("any_accept");
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (!ok) timeout("idle");
    endtask

    task automatic set_req(input int i, input bit v, input bit mode, input logic [DW-1:0] d);
        bus.req_valid[i] = v;
        bus.req_mode[i]  = mode;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic do_op(input int i, input bit mode, input logic [DW-1:0] d);
        set_req(i, 1'b1, mode, d);
        wait_accept(i);
        bus.req_valid[i] = 1'b0;
        wait_idle();
    endtask

    initial begin : driver
        int n;
        int id;
        int ks[$];
        logic [DW-1:0] pt;
        logic [1:0] acc;
        bus.req_valid = '0; bus.req_mode = '0; bus.req_data = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single encrypt from requester 0: latency and tag
        pt = 128'h00112233445566778899aabbccddeeff;
        set_req(0, 1'b1, 1'b0, pt);
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); n++;
            if (bus.rsp_valid) break;
        end
        chk("enc_latency", n, 13);
        chk("enc_rsp_id", bus.rsp_id, 0);
        chk("enc_rsp_data", bus.rsp_data, expect_result(pt, 1'b0));
        wait_idle();

        // Single decrypt from requester 1: key index must count 10 down to 0
        set_req(1, 1'b1, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (core_load || core_en) ks.push_back(int'(key_sel));
            if (bus.rsp_valid) break;
        end
        chk("dec_key_count", ks.size(), 11);
        for (int j = 0; j < ks.size(); j++) chk("dec_key_seq", ks[j], 10 - j);
        chk("dec_rsp_id", bus.rsp_id, 1);
        wait_idle();

        // Contention: both held valid for four ops
        set_req(0, 1'b1, $urandom_range(0, 1) == 1, rnd128());
        set_req(1, 1'b1, $urandom_range(0, 1) == 1, rnd128());
        for (int k = 0; k < 4; k++) begin
            wait_any_accept(id);
            chk("contention_grant", id, k % 2);
            if (id >= 0) bus.req_data[id*DW +: DW] = rnd128();
        end
        bus.req_valid = '0;
        wait_idle();

        // Random traffic with random response backpressure
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !bus.req_valid[i])
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd128());
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Backpressure: response held 20 cycles, waiting requester not granted
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, rnd128());
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin n = 1; break; end
        end
        if (n == 0) timeout("bp_rsp_valid");
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b1, rnd128());
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_no_grant", bus.req_ready, 0);
            chk("bp_rsp_hold", bus.rsp_valid, 1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rsp_last", bus.rsp_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_done", bus.rsp_valid, 0);
        chk("bp_next_grant", bus.req_ready, 2'b10);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_idle();

        // Reset during round 5
        set_req(0, 1'b1, 1'b0, rnd128());
        wait_accept(0);
        bus.req_valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_core_en", core_en, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_core_en", core_en, 0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // After reset: requester 0 wins, then 3 encrypts and 2 decrypts total
        set_req(0, 1'b1, 1'b0, rnd128());
        set_req(1, 1'b1, 1'b1, rnd128());
        wait_any_accept(id);
        chk("post_rst_grant", id, 0);
        bus.req_valid[0] = 1'b0;
        wait_accept(1);
        bus.req_valid[1] = 1'b0;
        wait_idle();
        do_op(0, 1'b0, rnd128());
        do_op(1, 1'b0, rnd128());
        do_op(1, 1'b1, rnd128());
        @(negedge clk);
`ifdef AES_SCHED_STATS_EN
        chk("stats_enc_total", st_enc, 3);
        chk("stats_dec_total", st_dec, 2);
`else
        chk("stats_enc_total", st_enc, 0);
        chk("stats_dec_total", st_dec, 0);
`endif
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time bound expired");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_core_scheduler.md
Name: aes_core_scheduler

Overview:
Arbitrates two requesters (e.g. encrypt client, decrypt client) onto one shared iterative AES round datapath. It sequences the round datapath through the initial AddRoundKey and Nr rounds, and drives the round-key index for forward or inverse key order. It captures the result and returns it on a valid/ready response port tagged with the requester id. It sits between the top-level sequencing logic and the AESEncrypt/AESDecrypt round core, replacing free-running cycle counters.

Parameters:
NR, 10, number of AES rounds (10/12/14 for AES-128/192/256)
DATA_W, 128, block width in bits
RIDX_W, 4, width of round index / key select

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept; at most one bit high
req_mode  input  2  per-requester op: 0=encrypt, 1=decrypt
req_data  input  2*DATA_W  per-requester block; requester i at [i*DATA_W +: DATA_W]
core_load  output  1  load core state with core_din XOR round key key_sel
core_en  output  1  core performs one round this cycle
core_last  output  1  current round is final (no MixColumns)
core_mode  output  1  core direction, held stable for whole op
core_din  output  DATA_W  registered block of granted request
key_sel  output  RIDX_W  round-key index into expanded key bus
core_dout  input  DATA_W  core state register output
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_data  output  DATA_W  result block
rsp_id  output  1  requester that issued the op
rsp_mode  output  1  op mode of response
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0. last_grant=1, so requester 0 wins first contention. Takes effect mid-op; the op in flight is dropped, no response.
- FSM states: IDLE, LOAD, ROUND, CAPTURE, RESP.
- IDLE: req_ready = one-hot grant of round-robin arbiter, combinational from req_valid and last_grant. Single valid wins. Both valid: grant !last_grant. On handshake, register data, mode and id; last_grant<=id; ->LOAD.
- LOAD (1 cycle): core_load=1. key_sel=0 for encrypt, NR for decrypt. round_idx<=1. ->ROUND.
- ROUND (NR cycles): core_en=1. key_sel=round_idx for encrypt, NR-round_idx for decrypt. core_last=1 when round_idx==NR. round_idx increments; at NR ->CAPTURE.
- CAPTURE (1 cycle): rsp_data<=core_dout; rsp_valid<=1. ->RESP.
- RESP: hold rsp_* stable until rsp_valid&&rsp_ready, then rsp_valid<=0, ->IDLE. Backpressure is unbounded.
- Latency: handshake in cycle T gives rsp_valid high from cycle T+NR+3 (13 for NR=10).
- Max throughput: one op per NR+4 cycles with rsp_ready tied high.
- req_ready is 0 outside IDLE. Requests arriving during an op wait; no queueing.
- Outside LOAD/ROUND: core_load=core_en=core_last=0. core_mode/core_din hold the last op's values.
- key_sel width: RIDX_W must satisfy 2^RIDX_W > NR. Elaboration error otherwise.

Optional Feature:
Macro AES_SCHED_STATS_EN.
- Defined: adds outputs stat_enc_cnt[15:0] and stat_dec_cnt[15:0]. Each increments on a response handshake of its mode, saturates at 16'hFFFF, and resets to 0.
- Undefined: the ports still exist, tied to 0, with no counter flops.

Decomposition:
- Package aes_sched_pkg: NR default, mode encodings MODE_ENC/MODE_DEC, state enum, RIDX_W.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs: valid[1:0], last_grant, enable. Outputs: one-hot grant and grant id.

Test Plan:
- Single encrypt: req0 data 00112233445566778899aabbccddeeff with key 000102…0f. Expect rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_valid at T+13.
- Single decrypt: req1 69c4e0d8…c55a, mode=1. Expect rsp 00112233…eeff, rsp_id=1, key_sel sequence 10,9,…,0.
- Contention: both req_valid held high for 4 ops. Expect grants 0,1,0,1 and req_ready never both high.
- Backpressure: rsp_ready low 20 cycles after rsp_valid. Expect rsp_* stable, req_ready 0, no new grant; completion on the cycle rsp_ready rises.
- Reset mid-op: rst_n low during ROUND round 5. Expect immediate busy=0 and core_en=0, no response; next op starts with a requester-0 grant.
- Stats (macro on): 3 encrypts + 2 decrypts. Expect stat_enc_cnt=3, stat_dec_cnt=2. Macro off: both 0.
